// File: rtl/call_stack_if.sv
// Push/pop/status bundle for call_stack. With CALL_STACK_PEEK_EN defined, the
// interface also carries the peek_idx/peek_data/peek_valid signals.
interface call_stack_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef CALL_STACK_PEEK_EN
  logic [CNT_W-1:0] peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;

  modport master (
    output push, pop, din, clr_err, peek_idx,
    input  dout, count, empty, full, overflow, underflow, peek_data, peek_valid
  );
  modport slave (
    input  push, pop, din, clr_err, peek_idx,
    output dout, count, empty, full, overflow, underflow, peek_data, peek_valid
  );
`else
  modport master (
    output push, pop, din, clr_err,
    input  dout, count, empty, full, overflow, underflow
  );
  modport slave (
    input  push, pop, din, clr_err,
    output dout, count, empty, full, overflow, underflow
  );
`endif
endinterface

// File: rtl/call_stack.sv
// Parametrised return-address stack with count/status, sticky error flags,
// reject or circular overflow and push+pop replace-top. Optional CALL_STACK_PEEK_EN.
module call_stack #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  call_stack_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_REPLACE,
    OP_UNDERFLOW
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PTR_W-1:0] ptr_inc, ptr_top;
  logic             is_empty, is_full;
  logic             we;
  logic [PTR_W-1:0] waddr;
  op_e              op;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_W'(DEPTH));
  assign ptr_inc  = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_top  = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);

  always_comb begin
    op = OP_HOLD;
    unique case ({bus.push, bus.pop})
      2'b10:   op = is_full  ? OP_PUSH_FULL : OP_PUSH;
      2'b01:   op = is_empty ? OP_UNDERFLOW : OP_POP;
      2'b11:   op = is_empty ? OP_UNDERFLOW : OP_REPLACE;
      default: op = OP_HOLD;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = bus.clr_err ? 1'b0 : ovf_q;
    unf_d = bus.clr_err ? 1'b0 : unf_q;
    we    = 1'b0;
    waddr = ptr_q;
    case (op)
      OP_PUSH: begin
        we    = 1'b1;
        ptr_d = ptr_inc;
        cnt_d = cnt_q + CNT_W'(1);
      end
      OP_PUSH_FULL: begin
        // Circular mode: the free slot is the oldest entry, so write there and keep count at DEPTH.
        ovf_d = 1'b1;
        if (OVF_MODE == 1) begin
          we    = 1'b1;
          ptr_d = ptr_inc;
        end
      end
      OP_POP: begin
        ptr_d = ptr_top;
        cnt_d = cnt_q - CNT_W'(1);
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = ptr_top;
      end
      OP_UNDERFLOW: unf_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) mem_q[waddr] <= bus.din;
  end

  assign bus.dout      = is_empty ? '0 : mem_q[ptr_top];
  assign bus.count     = cnt_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

`ifdef CALL_STACK_PEEK_EN
  int               pk_pos;
  logic [PTR_W-1:0] pk_addr;
  logic             pk_valid;

  assign pk_valid = (bus.peek_idx < cnt_q);

  // peek_idx < count <= DEPTH when valid, so a single +DEPTH restores the modulo.
  always_comb begin
    pk_pos  = 0;
    pk_addr = '0;
    if (pk_valid) begin
      pk_pos = int'(ptr_q) - 1 - int'(bus.peek_idx);
      if (pk_pos < 0) pk_pos = pk_pos + int'(DEPTH);
      pk_addr = PTR_W'(pk_pos);
    end
  end

  assign bus.peek_valid = pk_valid;
  assign bus.peek_data  = pk_valid ? mem_q[pk_addr] : '0;
`endif
endmodule

// File: tb/tb_call_stack.sv
// Directed bench: two call_stack instances (reject and circular overflow) share one stimulus.
module tb_call_stack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] din = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  call_stack_if #(.WIDTH(12), .CNT_W(4)) if0 ();
  call_stack_if #(.WIDTH(12), .CNT_W(4)) if1 ();

  assign if0.push = push;  assign if1.push = push;
  assign if0.pop = pop;    assign if1.pop = pop;
  assign if0.din = din;    assign if1.din = din;
  assign if0.clr_err = clr_err;  assign if1.clr_err = clr_err;

`ifdef CALL_STACK_PEEK_EN
  logic [3:0] peek_idx = '0;
  assign if0.peek_idx = peek_idx;
  assign if1.peek_idx = peek_idx;
`endif

  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  call_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic cyc(input logic p, input logic q, input logic [11:0] d, input logic c);
    push = p; pop = q; din = d; clr_err = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1'b0, 1'b1, 12'h0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 12'(i + 5), 1'b0);
    cyc(1'b0, 1'b1, 12'h0, 1'b0);
    do_reset();
    total++; if (if0.count !== 4'd0) begin bad++; $display("FAIL reset_count0 got=%0d exp=0", if0.count); end
    total++; if (if1.count !== 4'd0) begin bad++; $display("FAIL reset_count1 got=%0d exp=0", if1.count); end
    total++; if (if0.empty !== 1'b1 || if0.full !== 1'b0) begin bad++; $display("FAIL reset_status0 got=%b%b exp=10", if0.empty, if0.full); end
    total++; if (if0.dout !== 12'h000) begin bad++; $display("FAIL reset_dout0 got=%h exp=000", if0.dout); end
    total++; if (if1.dout !== 12'h000) begin bad++; $display("FAIL reset_dout1 got=%h exp=000", if1.dout); end
    total++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin bad++; $display("FAIL reset_flags0 got=%b%b exp=00", if0.overflow, if0.underflow); end
    total++; if (if1.overflow !== 1'b0 || if1.underflow !== 1'b0) begin bad++; $display("FAIL reset_flags1 got=%b%b exp=00", if1.overflow, if1.underflow); end
  endtask

  task automatic test_lifo();
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 12'(i), 1'b0);
    total++; if (if0.full !== 1'b1 || if0.count !== 4'd8) begin bad++; $display("FAIL lifo_full got=%b/%0d exp=1/8", if0.full, if0.count); end
    for (int i = 8; i >= 1; i--) begin
      total++; if (if0.dout !== 12'(i)) begin bad++; $display("FAIL lifo_pop got=%h exp=%h", if0.dout, 12'(i)); end
      cyc(1'b0, 1'b1, 12'h0, 1'b0);
    end
    total++; if (if0.empty !== 1'b1 || if0.dout !== 12'h000) begin bad++; $display("FAIL lifo_empty got=%b/%h exp=1/000", if0.empty, if0.dout); end
    total++; if (if0.underflow !== 1'b0) begin bad++; $display("FAIL lifo_unf got=%b exp=0", if0.underflow); end
  endtask

  task automatic test_overflow();
    logic [11:0] e0, e1;
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 12'(i), 1'b0);
    cyc(1'b1, 1'b0, 12'hABC, 1'b0);
    total++; if (if0.overflow !== 1'b1 || if0.count !== 4'd8 || if0.dout !== 12'h008) begin bad++; $display("FAIL ovf_reject got=%b/%0d/%h exp=1/8/008", if0.overflow, if0.count, if0.dout); end
    total++; if (if1.overflow !== 1'b1 || if1.count !== 4'd8 || if1.dout !== 12'hABC) begin bad++; $display("FAIL ovf_circ got=%b/%0d/%h exp=1/8/abc", if1.overflow, if1.count, if1.dout); end
    for (int i = 0; i < 8; i++) begin
      e0 = 12'(8 - i);
      e1 = (i == 0) ? 12'hABC : 12'(9 - i);
      total++; if (if0.dout !== e0) begin bad++; $display("FAIL ovf_pop0 got=%h exp=%h", if0.dout, e0); end
      total++; if (if1.dout !== e1) begin bad++; $display("FAIL ovf_pop1 got=%h exp=%h", if1.dout, e1); end
      cyc(1'b0, 1'b1, 12'h0, 1'b0);
    end
    total++; if (if1.empty !== 1'b1 || if0.empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b%b exp=11", if0.empty, if1.empty); end
    total++; if (if0.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", if0.overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b0, 1'b1, 12'h0, 1'b0);
    total++; if (if0.underflow !== 1'b1 || if0.count !== 4'd0) begin bad++; $display("FAIL unf_set got=%b/%0d exp=1/0", if0.underflow, if0.count); end
    cyc(1'b0, 1'b1, 12'h0, 1'b1);
    total++; if (if0.underflow !== 1'b1) begin bad++; $display("FAIL unf_set_wins got=%b exp=1", if0.underflow); end
    cyc(1'b0, 1'b0, 12'h0, 1'b1);
    total++; if (if0.underflow !== 1'b0 || if1.underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b%b exp=00", if0.underflow, if1.underflow); end
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 12'(i), 1'b0);
    cyc(1'b0, 1'b0, 12'h0, 1'b1);
    total++; if (if0.overflow !== 1'b0 || if0.count !== 4'd8) begin bad++; $display("FAIL ovf_clear got=%b/%0d exp=0/8", if0.overflow, if0.count); end
  endtask

  task automatic test_replace();
    do_reset();
    cyc(1'b1, 1'b0, 12'h100, 1'b0);
    cyc(1'b1, 1'b0, 12'h200, 1'b0);
    cyc(1'b1, 1'b1, 12'h300, 1'b0);
    total++; if (if0.count !== 4'd2 || if0.dout !== 12'h300) begin bad++; $display("FAIL repl_top got=%0d/%h exp=2/300", if0.count, if0.dout); end
    cyc(1'b0, 1'b1, 12'h0, 1'b0);
    total++; if (if0.count !== 4'd1 || if0.dout !== 12'h100) begin bad++; $display("FAIL repl_pop got=%0d/%h exp=1/100", if0.count, if0.dout); end
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 12'(i + 2), 1'b0);
    cyc(1'b1, 1'b1, 12'h055, 1'b0);
    total++; if (if0.overflow !== 1'b0 || if0.count !== 4'd8 || if0.dout !== 12'h055) begin bad++; $display("FAIL repl_full got=%b/%0d/%h exp=0/8/055", if0.overflow, if0.count, if0.dout); end
    do_reset();
    cyc(1'b1, 1'b1, 12'h777, 1'b0);
    total++; if (if0.underflow !== 1'b1 || if0.count !== 4'd0 || if0.dout !== 12'h000) begin bad++; $display("FAIL repl_empty got=%b/%0d/%h exp=1/0/000", if0.underflow, if0.count, if0.dout); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 12'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      total++; if (if1.dout !== 12'(19 - i)) begin bad++; $display("FAIL wrap_pop1 got=%h exp=%h", if1.dout, 12'(19 - i)); end
      total++; if (if0.dout !== 12'(7 - i)) begin bad++; $display("FAIL wrap_pop0 got=%h exp=%h", if0.dout, 12'(7 - i)); end
      cyc(1'b0, 1'b1, 12'h0, 1'b0);
    end
    total++; if (if1.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", if1.empty); end
    cyc(1'b1, 1'b0, 12'h011, 1'b0);
    cyc(1'b1, 1'b0, 12'h022, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 12'h033, 1'b0);
    rst_n = 1'b1;
    total++; if (if1.count !== 4'd0 || if1.dout !== 12'h000) begin bad++; $display("FAIL rst_mid_op got=%0d/%h exp=0/000", if1.count, if1.dout); end
    total++; if (if0.count !== 4'd0 || if0.empty !== 1'b1) begin bad++; $display("FAIL rst_mid_op0 got=%0d/%b exp=0/1", if0.count, if0.empty); end
  endtask

`ifdef CALL_STACK_PEEK_EN
  task automatic test_peek();
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 12'(i), 1'b0);
    peek_idx = 4'd3; #1;
    total++; if (if0.peek_valid !== 1'b1 || if0.peek_data !== 12'h002) begin bad++; $display("FAIL peek3 got=%b/%h exp=1/002", if0.peek_valid, if0.peek_data); end
    peek_idx = 4'd0; #1;
    total++; if (if0.peek_valid !== 1'b1 || if0.peek_data !== 12'h005) begin bad++; $display("FAIL peek0 got=%b/%h exp=1/005", if0.peek_valid, if0.peek_data); end
    peek_idx = 4'd5; #1;
    total++; if (if0.peek_valid !== 1'b0 || if0.peek_data !== 12'h000) begin bad++; $display("FAIL peek5 got=%b/%h exp=0/000", if0.peek_valid, if0.peek_data); end
    peek_idx = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_wrap();
`ifdef CALL_STACK_PEEK_EN
    test_peek();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
